uart_tx_arbiter: RTL and testbench



---
 rtl/uart_tx_arbiter_if.sv | 26 ++
 rtl/uart_tx_arbiter.sv | 154 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Bundle between the message requesters, the arbiter and the single uart_tx.
// master = arbiter side, slave = requesters plus transmitter side.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_BITS = 8
);
    logic [NUM_REQ-1:0]           req;
    logic [NUM_REQ*DATA_BITS-1:0] req_data;
    logic [NUM_REQ-1:0]           ack;
    logic [NUM_REQ-1:0]           grant;
    logic                         tx_start;
    logic [DATA_BITS-1:0]         tx_data;
    logic                         tx_busy;
    logic                         tx_done;
    logic                         timeout;

    modport master (
        input  req, req_data, tx_busy, tx_done,
        output ack, grant, tx_start, tx_data, timeout
    );

    modport slave (
        output req, req_data, tx_busy, tx_done,
        input  ack, grant, tx_start, tx_data, timeout
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx among NUM_REQ requesters.
// One byte per grant; ack on tx_done, timeout pulse if the transmitter stalls.
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int DATA_BITS      = 8,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                  clk,
    input  logic                  rst,
    uart_tx_arbiter_if.master     bus
);
    localparam int LW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TW-1:0] TIMER_LAST = (TIMEOUT_CYCLES > 0) ? TW'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [TW-1:0] TIMER_MAX  = '1;
    localparam logic [LW-1:0] LAST_RST   = LW'(NUM_REQ - 1);
    localparam bit            TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_RELEASE
    } state_t;

    state_t               state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [NUM_REQ-1:0]   ack_q, ack_d;
    logic                 tx_start_q, tx_start_d;
    logic [DATA_BITS-1:0] tx_data_q, tx_data_d;
    logic                 timeout_q, timeout_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic [LW-1:0]        last_q, last_d;
    logic [LW-1:0]        owner_q, owner_d;

    logic [DATA_BITS-1:0] req_bytes [NUM_REQ];
    logic                 found;
    logic [LW-1:0]        winner;
    logic [LW-1:0]        cand;
    logic [TW-1:0]        timer_inc;
    logic                 expired;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
        assign req_bytes[gi] = bus.req_data[gi*DATA_BITS +: DATA_BITS];
    end

    // Search starts just after the last owner so every requester gets a turn.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = LW'((int'(last_q) + 1 + k) % NUM_REQ);
            if (!found && bus.req[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    assign timer_inc = (timer_q == TIMER_MAX) ? timer_q : timer_q + 1'b1;
    assign expired   = TIMEOUT_EN && (timer_q == TIMER_LAST);

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        ack_d      = '0;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        timeout_d  = 1'b0;
        timer_d    = timer_q;
        last_d     = last_q;
        owner_d    = owner_q;

        case (state_q)
            S_IDLE: begin
                if (found) begin
                    grant_d    = NUM_REQ'(1) << winner;
                    tx_data_d  = req_bytes[winner];
                    tx_start_d = 1'b1;
                    owner_d    = winner;
                    state_d    = S_START;
                end
            end
            S_START: begin
                timer_d = '0;
                state_d = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                timer_d = timer_inc;
                // tx_done wins over an expiring timer in the same cycle.
                if (bus.tx_done) begin
                    ack_d   = grant_q;
                    state_d = S_RELEASE;
                end else if (expired) begin
                    timeout_d = 1'b1;
                    state_d   = S_RELEASE;
                end else if (bus.tx_busy) begin
                    state_d = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                timer_d = timer_inc;
                if (bus.tx_done) begin
                    ack_d   = grant_q;
                    state_d = S_RELEASE;
                end else if (expired) begin
                    timeout_d = 1'b1;
                    state_d   = S_RELEASE;
                end
            end
            S_RELEASE: begin
                grant_d = '0;
                last_d  = owner_q;
                state_d = S_IDLE;
            end
            default: begin
                grant_d = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            grant_q    <= '0;
            ack_q      <= '0;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
            timeout_q  <= 1'b0;
            timer_q    <= '0;
            last_q     <= LAST_RST;
            owner_q    <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            ack_q      <= ack_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            timeout_q  <= timeout_d;
            timer_q    <= timer_d;
            last_q     <= last_d;
            owner_q    <= owner_d;
        end
    end

    assign bus.grant    = grant_q;
    assign bus.ack      = ack_q;
    assign bus.tx_start = tx_start_q;
    assign bus.tx_data  = tx_data_q;
    assign bus.timeout  = timeout_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed + randomized bench for uart_tx_arbiter against a transaction-level
// model: round-robin pick from the last owner, ack/timeout from the done cycle.
module tb_uart_tx_arbiter;
    localparam int NR = 4;
    localparam int DB = 8;
    localparam int T  = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    logic [NR-1:0] req_v;
    logic [DB-1:0] data_m [NR];
    int            last_m;

    uart_tx_arbiter_if #(.NUM_REQ(NR), .DATA_BITS(DB)) bus_if ();

    uart_tx_arbiter #(
        .NUM_REQ(NR),
        .DATA_BITS(DB),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req();
        bus_if.req = req_v;
        for (int i = 0; i < NR; i++) bus_if.req_data[i*DB +: DB] = data_m[i];
    endtask

    function automatic logic [NR-1:0] onehot(input int i);
        return NR'(1) << i;
    endfunction

    // Reference arbitration: first requester after the last owner, wrapping.
    function automatic int rr_pick(input logic [NR-1:0] r, input int last);
        for (int d = 1; d <= NR; d++) begin
            if (r[(last + d) % NR]) return (last + d) % NR;
        end
        return -1;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        check("rst_grant", bus_if.grant, 0);
        check("rst_ack", bus_if.ack, 0);
        check("rst_tx_start", bus_if.tx_start, 0);
        check("rst_tx_data", bus_if.tx_data, 0);
        check("rst_timeout", bus_if.timeout, 0);
        rst    = 1'b0;
        last_m = NR - 1;
    endtask

    // One full transaction, entered in the cycle where req is presented.
    // done_at = cycle after tx_start in which tx_done pulses; beyond T -> timeout.
    task automatic txn(input string tag, input int exp_idx, input int done_at,
                       input bit busy_en, input bit drop);
        int            n;
        bit            exp_to;
        int            end_j;
        logic [NR-1:0] oh;
        logic [DB-1:0] exp_data;
        oh       = onehot(exp_idx);
        exp_data = data_m[exp_idx];
        exp_to   = (T != 0) && (done_at > T);
        end_j    = exp_to ? T : done_at;
        n = 0;
        do begin
            tick();
            n++;
        end while (bus_if.tx_start !== 1'b1 && n < 40);
        check({tag, "_latency"}, n, 1);
        if (bus_if.tx_start !== 1'b1) return;
        check({tag, "_grant"}, bus_if.grant, oh);
        check({tag, "_tx_data"}, bus_if.tx_data, exp_data);
        for (int j = 1; j <= end_j; j++) begin
            tick();
            if (j == 1) check({tag, "_start_pulse"}, bus_if.tx_start, 0);
            check({tag, "_hold"}, {bus_if.grant, bus_if.ack, bus_if.timeout}, {oh, NR'(0), 1'b0});
            bus_if.tx_busy = busy_en && (j < done_at);
            bus_if.tx_done = (j == done_at);
            if (drop && j == 2) begin
                req_v[exp_idx] = 1'b0;
                drive_req();
            end
        end
        tick();
        bus_if.tx_busy = 1'b0;
        bus_if.tx_done = 1'b0;
        check({tag, "_ack"}, bus_if.ack, exp_to ? NR'(0) : oh);
        check({tag, "_timeout"}, bus_if.timeout, exp_to);
        check({tag, "_rel_grant"}, bus_if.grant, oh);
        check({tag, "_data_hold"}, bus_if.tx_data, exp_data);
        last_m = exp_idx;
        tick();
        check({tag, "_idle"}, {bus_if.grant, bus_if.ack, bus_if.timeout, bus_if.tx_start}, 0);
        $display("txn %s owner=%0d data=%02h timeout=%0d", tag, exp_idx, exp_data, exp_to);
    endtask

    initial begin
        int pick;
        req_v = '0;
        for (int i = 0; i < NR; i++) data_m[i] = '0;
        bus_if.tx_busy = 1'b0;
        bus_if.tx_done = 1'b0;
        drive_req();
        do_reset();

        // Single requester, 10 busy cycles then done.
        data_m[0] = 8'h5A;
        req_v = 4'b0001;
        drive_req();
        txn("single", 0, 11, 1'b1, 1'b0);
        req_v = '0;
        drive_req();

        // All four held high: strict rotation, then wrap-around search.
        do_reset();
        for (int i = 0; i < NR; i++) data_m[i] = DB'(8'h10 + i);
        req_v = 4'b1111;
        drive_req();
        txn("rr0", 0, $urandom_range(1, 12), 1'b1, 1'b0);
        txn("rr1", 1, $urandom_range(1, 12), 1'b1, 1'b0);
        txn("rr2", 2, $urandom_range(1, 12), 1'b1, 1'b0);
        txn("rr3", 3, $urandom_range(1, 12), 1'b1, 1'b0);
        txn("rr0b", 0, $urandom_range(1, 12), 1'b1, 1'b0);
        txn("rr1b", 1, $urandom_range(1, 12), 1'b1, 1'b0);
        txn("rr2b", 2, $urandom_range(1, 12), 1'b1, 1'b0);
        req_v = 4'b0101;
        drive_req();
        txn("wrap0", 0, $urandom_range(1, 12), 1'b1, 1'b0);
        txn("wrap2", 2, $urandom_range(1, 12), 1'b1, 1'b0);

        // Timeout without busy, another requester next, then the retry times out in WAIT_DONE.
        for (int i = 0; i < NR; i++) data_m[i] = DB'($urandom);
        req_v = 4'b0110;
        drive_req();
        txn("to_nobusy", 1, 1000, 1'b0, 1'b0);
        txn("to_other", 2, 4, 1'b1, 1'b0);
        txn("to_retry", 1, 1000, 1'b1, 1'b0);

        // tx_done on the expiry cycle is a success.
        req_v = 4'b1000;
        drive_req();
        txn("coincide", 3, T, 1'b1, 1'b0);

        // Requester drops req mid-transaction; ack still pulses.
        req_v = 4'b0011;
        drive_req();
        txn("drop", 0, 5, 1'b1, 1'b1);
        req_v = 4'b0010;
        drive_req();
        txn("after_drop", 1, 3, 1'b1, 1'b0);

        // Randomized rounds against the reference pick.
        for (int r = 0; r < 10; r++) begin
            req_v = NR'($urandom_range(1, (1 << NR) - 1));
            for (int i = 0; i < NR; i++) data_m[i] = DB'($urandom);
            drive_req();
            pick = rr_pick(req_v, last_m);
            txn($sformatf("rand%0d", r), pick, $urandom_range(1, T + 4),
                1'($urandom_range(0, 1)), 1'b0);
        end

        // Reset during WAIT_DONE, with last owner 0 beforehand.
        req_v = 4'b0001;
        drive_req();
        txn("pre_rst", 0, 2, 1'b1, 1'b0);
        req_v = 4'b0010;
        data_m[1] = 8'hC3;
        drive_req();
        tick();
        check("mid_start", bus_if.tx_start, 1);
        tick();
        bus_if.tx_busy = 1'b1;
        tick();
        tick();
        check("mid_grant", bus_if.grant, 4'b0010);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_grant", bus_if.grant, 0);
        check("mid_rst_start_ack", {bus_if.tx_start, bus_if.ack, bus_if.timeout}, 0);
        check("mid_rst_data", bus_if.tx_data, 0);
        req_v = '0;
        drive_req();
        bus_if.tx_busy = 1'b0;
        @(posedge clk);
        #1;
        rst    = 1'b0;
        last_m = NR - 1;
        bus_if.tx_done = 1'b1;
        tick();
        bus_if.tx_done = 1'b0;
        check("idle_done_ignored", {bus_if.grant, bus_if.ack, bus_if.timeout, bus_if.tx_start}, 0);
        tick();
        for (int i = 0; i < NR; i++) data_m[i] = DB'($urandom);
        req_v = 4'b1111;
        drive_req();
        txn("post_rst", 0, 3, 1'b1, 1'b0);
        req_v = '0;
        drive_req();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
